// File: rtl/feature_frame_loader.sv
// feature_frame_loader
//   Collects N_FEAT serial feature samples into a parallel frame, hands the
//   frame to the ANN with a one-cycle start pulse, then holds it until the
//   ANN reports done.
//
//   Parameters : N_FEAT (features per frame), WIDTH (bits per feature),
//                MAX_VAL (clamp ceiling, only used with FEAT_CLAMP_EN)
//   Macro      : FEAT_CLAMP_EN -- when defined, stored samples are clamped
//                to MAX_VAL; otherwise they are stored unmodified.
//   Ports      : clk, rst (async, active high)
//                sample_in/sample_valid/sample_ready : sample stream in
//                flush        : drop the partial frame (FILL only)
//                frame_out    : packed frame, element 0 = first sample
//                ann_start    : one-cycle start pulse to the ANN
//                ann_done     : ANN finished the frame
//                fill_count   : samples held in the current frame
//                busy         : frame owned by the ANN
//                frames_done  : completed frame counter (wraps)

// One frame slot: a WIDTH-bit register written when selected.
module feature_slot #(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     q <= '0;
    else if (we) q <= d;
  end
endmodule

module feature_frame_loader #(
  parameter int N_FEAT  = 30,
  parameter int WIDTH   = 10,
  parameter int MAX_VAL = 1000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [WIDTH-1:0]              sample_in,
  input  logic                          sample_valid,
  output logic                          sample_ready,
  input  logic                          flush,
  output logic [N_FEAT-1:0][WIDTH-1:0]  frame_out,
  output logic                          ann_start,
  input  logic                          ann_done,
  output logic [4:0]                    fill_count,
  output logic                          busy,
  output logic [7:0]                    frames_done
);

`ifdef FEAT_CLAMP_EN
  localparam bit CLAMP_EN = 1'b1;
`else
  localparam bit CLAMP_EN = 1'b0;
`endif

  // Ceiling saturated to the sample width so a large MAX_VAL cannot wrap.
  localparam logic [WIDTH-1:0] MAX_W =
    (MAX_VAL >= (2**WIDTH)) ? {WIDTH{1'b1}} : WIDTH'(MAX_VAL);

  typedef enum logic [1:0] {FILL, LAUNCH, WAIT_DONE} state_t;

  state_t     state_q, state_d;
  logic [4:0] fill_q, fill_d;
  logic [7:0] done_q, done_d;
  logic       accept, store;
  logic [WIDTH-1:0] wr_data;

  assign sample_ready = (state_q == FILL);
  assign accept       = sample_valid && sample_ready;
  // flush wins over a simultaneous transfer: the sample is dropped.
  assign store        = accept && !flush;
  assign wr_data      = (CLAMP_EN && (sample_in > MAX_W)) ? MAX_W : sample_in;

  always_comb begin
    state_d = state_q;
    fill_d  = fill_q;
    done_d  = done_q;
    unique case (state_q)
      FILL: begin
        if (flush) begin
          fill_d = '0;
        end else if (accept) begin
          fill_d = fill_q + 5'd1;
          if (fill_q == 5'(N_FEAT - 1)) state_d = LAUNCH;
        end
      end
      LAUNCH: state_d = WAIT_DONE;
      WAIT_DONE: begin
        if (ann_done) begin
          state_d = FILL;
          fill_d  = '0;
          done_d  = done_q + 8'd1;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FILL;
      fill_q  <= '0;
      done_q  <= '0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      done_q  <= done_d;
    end
  end

  // Slots are only written in FILL, so the frame is frozen while the ANN
  // owns it; they are never cleared on return to FILL, just overwritten.
  for (genvar i = 0; i < N_FEAT; i++) begin : g_slot
    feature_slot #(.WIDTH(WIDTH)) u_slot (
      .clk (clk),
      .rst (rst),
      .we  (store && (fill_q == 5'(i))),
      .d   (wr_data),
      .q   (frame_out[i])
    );
  end

  assign ann_start   = (state_q == LAUNCH);
  assign busy        = (state_q != FILL);
  assign fill_count  = fill_q;
  assign frames_done = done_q;

endmodule

// File: tb/tb_feature_frame_loader.sv
module tb_feature_frame_loader;
  localparam int N = 30;
  localparam int W = 10;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [W-1:0]         sample_in = '0;
  logic                 sample_valid = 1'b0;
  logic                 sample_ready;
  logic                 flush = 1'b0;
  logic [N-1:0][W-1:0]  frame_out;
  logic                 ann_start;
  logic                 ann_done = 1'b0;
  logic [4:0]           fill_count;
  logic                 busy;
  logic [7:0]           frames_done;

  int checks = 0;
  int errors = 0;

  feature_frame_loader #(.N_FEAT(N), .WIDTH(W), .MAX_VAL(1000)) dut (
    .clk          (clk),
    .rst          (rst),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .flush        (flush),
    .frame_out    (frame_out),
    .ann_start    (ann_start),
    .ann_done     (ann_done),
    .fill_count   (fill_count),
    .busy         (busy),
    .frames_done  (frames_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_frame(input string tag, input logic [N-1:0][W-1:0] exp);
    checks++;
    assert (frame_out === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, frame_out, exp);
    end
  endtask

  // Fill a full frame with value v, verify launch, then complete it.
  task automatic run_frame(input logic [W-1:0] v);
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      sample_valid = 1'b1;
      sample_in    = v;
    end
    @(negedge clk);
    sample_valid = 1'b0;
    chk("frame_launch", 32'(ann_start), 32'd1);
    @(negedge clk);
    ann_done = 1'b1;
    @(negedge clk);
    ann_done = 1'b0;
  endtask

  logic [N-1:0][W-1:0] exp_f;
  logic [7:0]          fd_prev;

  initial begin
    // Reset state (async, before any clock edge)
    #1;
    chk("rst_fill", 32'(fill_count), 32'd0);
    chk("rst_frames", 32'(frames_done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_start", 32'(ann_start), 32'd0);
    chk("rst_ready", 32'(sample_ready), 32'd1);
    chk_frame("rst_frame", '0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // 30 transfers of 200
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      chk("fill_inc", 32'(fill_count), 32'(i));
      chk("no_early_start", 32'(ann_start), 32'd0);
      sample_valid = 1'b1;
      sample_in    = 10'd200;
    end
    @(negedge clk);
    sample_valid = 1'b0;
    chk("fill_full", 32'(fill_count), 32'd30);
    chk("start_pulse", 32'(ann_start), 32'd1);
    chk("busy_launch", 32'(busy), 32'd1);
    chk("ready_launch", 32'(sample_ready), 32'd0);
    for (int i = 0; i < N; i++) exp_f[i] = 10'd200;
    chk_frame("frame_200", exp_f);
    @(negedge clk);
    chk("start_once", 32'(ann_start), 32'd0);
    chk("busy_wait", 32'(busy), 32'd1);

    // WAIT_DONE: samples presented are not stored; ann_done in FILL ignored later
    for (int i = 0; i < 10; i++) begin
      sample_valid = 1'b1;
      sample_in    = '0;
      @(negedge clk);
      chk("ready_wait", 32'(sample_ready), 32'd0);
      chk_frame("frame_hold", exp_f);
    end
    sample_valid = 1'b0;
    flush        = 1'b1;   // ignored outside FILL
    ann_done     = 1'b1;
    @(negedge clk);
    ann_done = 1'b0;
    flush    = 1'b0;
    chk("done_fill", 32'(fill_count), 32'd0);
    chk("done_frames", 32'(frames_done), 32'd1);
    chk("done_busy", 32'(busy), 32'd0);
    chk("done_ready", 32'(sample_ready), 32'd1);

    // ann_done in FILL is ignored
    ann_done = 1'b1;
    @(negedge clk);
    ann_done = 1'b0;
    chk("done_in_fill", 32'(frames_done), 32'd1);

    // 12 transfers, then flush with a valid sample
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      sample_valid = 1'b1;
      sample_in    = W'(i + 1);
    end
    @(negedge clk);
    chk("fill_12", 32'(fill_count), 32'd12);
    flush     = 1'b1;
    sample_in = 10'd777;
    @(negedge clk);
    flush        = 1'b0;
    sample_valid = 1'b0;
    chk("flush_fill", 32'(fill_count), 32'd0);
    for (int i = 0; i < 12; i++) exp_f[i] = W'(i + 1);
    chk_frame("flush_drop", exp_f);

    // 30 transfers of 0
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      sample_valid = 1'b1;
      sample_in    = '0;
    end
    @(negedge clk);
    sample_valid = 1'b0;
    chk("start_zero", 32'(ann_start), 32'd1);
    chk_frame("frame_zero", '0);
    @(negedge clk);
    ann_done = 1'b1;
    @(negedge clk);
    ann_done = 1'b0;
    chk("frames_2", 32'(frames_done), 32'd2);

    // third frame, then fourth frame into WAIT_DONE and reset
    run_frame(10'd33);
    chk("frames_3", 32'(frames_done), 32'd3);
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      sample_valid = 1'b1;
      sample_in    = 10'd44;
    end
    @(negedge clk);
    sample_valid = 1'b0;
    @(negedge clk);
    chk("busy_pre_rst", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_fill", 32'(fill_count), 32'd0);
    chk("arst_frames", 32'(frames_done), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_start", 32'(ann_start), 32'd0);
    chk_frame("arst_frame", '0);
    @(negedge clk);
    rst = 1'b0;
    ann_done = 1'b1;
    @(negedge clk);
    ann_done = 1'b0;
    chk("late_done_frames", 32'(frames_done), 32'd0);
    chk("late_done_ready", 32'(sample_ready), 32'd1);

    // single 1023 sample
    @(negedge clk);
    sample_valid = 1'b1;
    sample_in    = 10'd1023;
    @(negedge clk);
    sample_valid = 1'b0;
    chk("single_fill", 32'(fill_count), 32'd1);
`ifdef FEAT_CLAMP_EN
    chk("clamp_val", 32'(frame_out[0]), 32'd1000);
`else
    chk("raw_val", 32'(frame_out[0]), 32'd1023);
`endif
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_single", 32'(fill_count), 32'd0);

    // 256 frames: counter wraps
    for (int f = 0; f < 255; f++) run_frame(W'(f));
    chk("frames_255", 32'(frames_done), 32'd255);
    fd_prev = frames_done;
    run_frame(10'd5);
    chk("frames_wrap", 32'(frames_done), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
